// File: rtl/alu_op_sequencer_if.sv
// Command/response bus between the control unit and the ALU op sequencer.
// master = control unit, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;
  logic             rsp_wb;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_flags, rsp_wb, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_flags, rsp_wb, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a registered 16-bit ALU from a command handshake; single ops
// take ISSUE/WAIT, MUL is a shift-add loop built from ALU adds.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [1:0]       alu_funsel,
  input  logic [WIDTH-1:0] alu_z,
  input  logic [3:0]       alu_flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP,
    M_ADD, M_ADDW, M_DBL, M_DBLW
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       fs_q, fs_d;
  logic             rdy_q, rdy_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [3:0]       rf_q, rf_d;
  logic             wb_q, wb_d;
  logic             err_q, err_d;
  logic             accept;
  logic             mul_done;

  assign accept = bus.cmd_valid & rdy_q;
  assign cnt_nx = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    fs_d     = fs_q;
    rv_d     = 1'b0;
    rd_d     = rd_q;
    rf_d     = rf_q;
    wb_d     = wb_q;
    err_d    = err_q;
    mul_done = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          op_d    = bus.cmd_op;
          x_d     = bus.cmd_a;
          y_d     = bus.cmd_b;
          state_d = ISSUE;
          unique case (1'b1)
            (bus.cmd_op == OP_ADD): fs_d = 2'b00;
            (bus.cmd_op == OP_SUB),
            (bus.cmd_op == OP_CMP): fs_d = 2'b01;
            (bus.cmd_op == OP_MOV): fs_d = 2'b10;
            (bus.cmd_op == OP_NEG): fs_d = 2'b11;
            (bus.cmd_op == OP_MUL): begin
              acc_d = '0;
              mc_d  = bus.cmd_a;
              mp_d  = bus.cmd_b;
              cnt_d = '0;
              fs_d  = 2'b00;
              if (bus.cmd_b[0]) begin
                x_d     = '0;
                y_d     = bus.cmd_a;
                state_d = M_ADD;
              end else begin
                y_d     = bus.cmd_a;
                state_d = M_DBL;
              end
            end
            default: begin
              x_d     = x_q;
              y_d     = y_q;
              state_d = RESP;
              rv_d    = 1'b1;
              rd_d    = '0;
              rf_d    = '0;
              wb_d    = 1'b0;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        rv_d    = 1'b1;
        rd_d    = (op_q == OP_CMP) ? '0 : alu_z;
        rf_d    = alu_flags;
        wb_d    = (op_q != OP_CMP);
        err_d   = 1'b0;
      end
      M_ADD: state_d = M_ADDW;
      M_ADDW: begin
        acc_d = alu_z;
        if (cnt_q == LAST) begin
          mul_done = 1'b1;
        end else begin
          x_d     = mc_q;
          y_d     = mc_q;
          state_d = M_DBL;
        end
      end
      M_DBL: state_d = M_DBLW;
      M_DBLW: begin
        mc_d  = alu_z;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_nx;
        // The doubled multiplicand is only visible on alu_z this cycle
        if (mp_q[1]) begin
          x_d     = acc_q;
          y_d     = alu_z;
          state_d = M_ADD;
        end else if (cnt_nx == LAST) begin
          mul_done = 1'b1;
        end else begin
          x_d     = alu_z;
          y_d     = alu_z;
          state_d = M_DBL;
        end
      end
      default: state_d = IDLE;
    endcase
    if (mul_done) begin
      state_d = RESP;
      rv_d    = 1'b1;
      rd_d    = acc_d;
      rf_d    = {acc_d[WIDTH-1], 2'b00, acc_d == '0};
      wb_d    = 1'b1;
      err_d   = 1'b0;
    end
    rdy_d = (state_d == IDLE) || (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 2'b00;
      rdy_q   <= 1'b1;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rf_q    <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rf_q    <= rf_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  assign alu_x         = x_q;
  assign alu_y         = y_q;
  assign alu_funsel    = fs_q;
  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rd_q;
  assign bus.rsp_flags = rf_q;
  assign bus.rsp_wb    = wb_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a registered ALU model
// and hand-computed directed vectors.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_x, alu_y, alu_z;
  logic [1:0]  alu_funsel;
  logic [3:0]  alu_flags;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    logic        wb;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_funsel (alu_funsel),
    .alu_z      (alu_z),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU partner: result and {S,V,C,Z} one edge after inputs
  function automatic logic [19:0] alu_f(logic [15:0] x, logic [15:0] y,
                                        logic [1:0] fs);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (fs)
      2'b00: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[15:0]; c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      2'b01: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        r = s[15:0]; c = s[16];
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      2'b10:   r = x;
      default: r = ~x + 16'd1;
    endcase
    return {r[15], v, c, r == 16'd0, r};
  endfunction

  initial begin
    alu_z = '0;
    alu_flags = '0;
  end

  always @(posedge clk) begin
    logic [19:0] o;
    o = alu_f(alu_x, alu_y, alu_funsel);
    alu_z     <= o[15:0];
    alu_flags <= o[19:16];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data %h err %b want none (cycle %0d)",
                 bus.rsp_data, bus.rsp_err, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_cycle", cyc, mon_e.cyc);
        chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, mon_e.d});
        chk("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, mon_e.f});
        chk("rsp_wb", {31'd0, bus.rsp_wb}, {31'd0, mon_e.wb});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] d,
                      input logic [3:0] f, input logic wb, input logic err,
                      input int lat, input bit expect_rsp,
                      output int c0);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got cmd_ready 0 want 1");
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    c0 = cyc;
    if (expect_rsp) begin
      e.d = d; e.f = f; e.wb = wb; e.err = err; e.cyc = c0 + lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, bus.rsp_data}, 32'd0);
    chk({tag, "_rflags"}, {28'd0, bus.rsp_flags}, 32'd0);
    chk({tag, "_alu_x"}, {16'd0, alu_x}, 32'd0);
    chk({tag, "_alu_y"}, {16'd0, alu_y}, 32'd0);
    chk({tag, "_funsel"}, {30'd0, alu_funsel}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    send(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 1, 0, 3, 1, c);
    send(3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b0011, 1, 0, 3, 1, c);
    send(3'b100, 16'h0003, 16'h0005, 16'h0000, 4'b1000, 0, 0, 3, 1, c);
    send(3'b011, 16'h0001, 16'h0000, 16'hFFFF, 4'b1000, 1, 0, 3, 1, c);
    send(3'b010, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1, 0, 3, 1, c);
    send(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 1, 0, 3, 1, c);
    send(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0110, 1, 0, 3, 1, c);
    send(3'b101, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1, 0, 35, 1, c);
    send(3'b101, 16'h0100, 16'h0100, 16'h0000, 4'b0001, 1, 0, 33, 1, c);
    send(3'b101, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000, 1, 0, 63, 1, c);
    send(3'b110, 16'h1111, 16'h2222, 16'h0000, 4'b0000, 0, 1, 1, 1, c);
    send(3'b111, 16'h3333, 16'h4444, 16'h0000, 4'b0000, 0, 1, 1, 1, c);

    // Busy: keep offering an illegal op; none may be taken
    send(3'b101, 16'h0007, 16'h0003, 16'h0015, 4'b0000, 1, 0, 35, 1, c);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b110;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.cmd_ready) break;
    end
    bus.cmd_valid = 1'b0;
    chk("busy_ready_return", {31'd0, bus.cmd_ready}, 32'd1);

    // Abort a MUL with reset in its cycle 10
    send(3'b101, 16'h0003, 16'h0005, 16'h0000, 4'b0000, 1, 0, 35, 0, c);
    while (cyc < c + 10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    send(3'b000, 16'h0002, 16'h0002, 16'h0004, 4'b0000, 1, 0, 3, 1, c);

    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
